// File: rtl/rv_pkg.sv
// Shared RV32I decode constants: opcodes, ALU op encoding, ID FSM states, NOP word.
package rv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  // SUB only exists for register-register ops; SRA/SRL share funct3 101 on both forms.
  function automatic alu_op_e alu_from_funct(input logic [2:0] f3, input logic alt,
                                             input logic is_op);
    case (f3)
      3'b000:  return (is_op && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv_decoder.sv
// Combinational RV32I decoder: register indices, immediate and control bundle.
module rv_decoder (
  input  logic [31:0] instr_i,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o,
  output logic [31:0] imm_o,
  output logic [3:0]  alu_op_o,
  output logic        alu_src_o,
  output logic        reg_write_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        branch_o,
  output logic        jump_o,
  output logic        illegal_o
);
  import rv_pkg::*;

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        wr;

  assign rs1_o = instr_i[19:15];
  assign rs2_o = instr_i[24:20];
  assign rd_o  = instr_i[11:7];

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  always_comb begin
    imm_o       = '0;
    alu_op_o    = ALU_ADD;
    alu_src_o   = 1'b0;
    wr          = 1'b0;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    branch_o    = 1'b0;
    jump_o      = 1'b0;
    illegal_o   = 1'b0;
    case (instr_i[6:0])
      OPC_LUI:    begin imm_o = imm_u; alu_op_o = ALU_PASSB; alu_src_o = 1'b1; wr = 1'b1; end
      OPC_AUIPC:  begin imm_o = imm_u; alu_src_o = 1'b1; wr = 1'b1; end
      OPC_JAL:    begin imm_o = imm_j; alu_src_o = 1'b1; wr = 1'b1; jump_o = 1'b1; end
      OPC_JALR:   begin imm_o = imm_i; alu_src_o = 1'b1; wr = 1'b1; jump_o = 1'b1; end
      OPC_BRANCH: begin imm_o = imm_b; alu_op_o = ALU_SUB; branch_o = 1'b1; end
      OPC_LOAD:   begin imm_o = imm_i; alu_src_o = 1'b1; wr = 1'b1; mem_read_o = 1'b1; end
      OPC_STORE:  begin imm_o = imm_s; alu_src_o = 1'b1; mem_write_o = 1'b1; end
      OPC_OP_IMM: begin
        imm_o     = imm_i;
        alu_op_o  = alu_from_funct(instr_i[14:12], instr_i[30], 1'b0);
        alu_src_o = 1'b1;
        wr        = 1'b1;
      end
      OPC_OP: begin
        alu_op_o = alu_from_funct(instr_i[14:12], instr_i[30], 1'b1);
        wr       = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase
    // x0 is hardwired; never request a write to it.
    reg_write_o = wr && (instr_i[11:7] != 5'd0);
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage with a one-entry skid buffer; in_ready depends only on registered state.
module id_stage #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_instr,
  output logic            in_ready,
  input  logic            flush,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic [3:0]      alu_op,
  output logic            alu_src,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            branch,
  output logic            jump,
  output logic            illegal
);
  import rv_pkg::*;

  state_e state_q, state_d;
  entry_t out_q, out_d, skid_q, skid_d, in_e, empty_e;
  logic   acc, cons;

  assign empty_e = '{pc: '0, instr: NOP_INSTR};
  assign in_e    = '{pc: in_pc, instr: in_instr};

  assign in_ready  = (state_q != ST_SKID);
  assign out_valid = (state_q != ST_EMPTY);
  assign out_pc    = out_q.pc;
  assign out_instr = out_q.instr;

  assign acc  = in_valid && in_ready;
  assign cons = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      out_d   = empty_e;
      skid_d  = empty_e;
    end else begin
      case (state_q)
        ST_EMPTY: if (acc) begin state_d = ST_FULL; out_d = in_e; end
        ST_FULL: begin
          if (acc && cons) out_d = in_e;
          else if (acc) begin state_d = ST_SKID; skid_d = in_e; end
          else if (cons) begin state_d = ST_EMPTY; out_d = empty_e; end
        end
        ST_SKID: if (cons) begin state_d = ST_FULL; out_d = skid_q; skid_d = empty_e; end
        default: begin state_d = ST_EMPTY; out_d = empty_e; skid_d = empty_e; end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      out_q   <= empty_e;
      skid_q  <= empty_e;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  logic [4:0]  d_rs1, d_rs2, d_rd;
  logic [31:0] d_imm;
  logic [3:0]  d_alu_op;
  logic        d_alu_src, d_reg_write, d_mem_read, d_mem_write, d_branch, d_jump, d_illegal;

  rv_decoder u_dec (
    .instr_i     (out_q.instr),
    .rs1_o       (d_rs1),
    .rs2_o       (d_rs2),
    .rd_o        (d_rd),
    .imm_o       (d_imm),
    .alu_op_o    (d_alu_op),
    .alu_src_o   (d_alu_src),
    .reg_write_o (d_reg_write),
    .mem_read_o  (d_mem_read),
    .mem_write_o (d_mem_write),
    .branch_o    (d_branch),
    .jump_o      (d_jump),
    .illegal_o   (d_illegal)
  );

  // The held word is NOP when empty, but gate anyway so an empty stage shows no controls.
  assign rs1       = out_valid ? d_rs1       : 5'd0;
  assign rs2       = out_valid ? d_rs2       : 5'd0;
  assign rd        = out_valid ? d_rd        : 5'd0;
  assign imm       = out_valid ? d_imm       : '0;
  assign alu_op    = out_valid ? d_alu_op    : 4'd0;
  assign alu_src   = out_valid && d_alu_src;
  assign reg_write = out_valid && d_reg_write;
  assign mem_read  = out_valid && d_mem_read;
  assign mem_write = out_valid && d_mem_write;
  assign branch    = out_valid && d_branch;
  assign jump      = out_valid && d_jump;
  assign illegal   = out_valid && d_illegal;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: ordered pc/instr stream plus directed decode checks.
module tb_id_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_pc, out_instr, imm;
  logic [4:0]  rs1, rs2, rd;
  logic [3:0]  alu_op;
  logic        alu_src, reg_write, mem_read, mem_write, branch, jump, illegal;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t sb_q[$];

  id_stage #(.XLEN(32), .NOP_INSTR(32'h0000_0013)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .in_ready(in_ready), .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
    .out_pc(out_pc), .out_instr(out_instr), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .alu_op(alu_op), .alu_src(alu_src), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .branch(branch), .jump(jump), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] ins,
                       input bit ordy, input bit fl);
    in_valid = v; in_pc = pc; in_instr = ins; out_ready = ordy; flush = fl;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Model of the upcoming edge: at most two words held, oldest at the output.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst) sb_q.delete();
      else begin
        bit   acc;
        ent_t e;
        chk("in_ready", {31'd0, in_ready}, {31'd0, sb_q.size() < 2});
        chk("out_valid", {31'd0, out_valid}, {31'd0, sb_q.size() != 0});
        if (flush) sb_q.delete();
        else begin
          acc = in_valid && (sb_q.size() < 2);
          if (out_valid && out_ready && sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("sb_pc", out_pc, e.pc);
            chk("sb_instr", out_instr, e.instr);
          end
          if (acc) sb_q.push_back('{pc: in_pc, instr: in_instr});
        end
      end
    end
  end

  function automatic logic [31:0] addi_w(input logic [31:0] pc);
    return 32'h0000_0013 | (pc << 20);
  endfunction

  initial begin
    drive(0, 0, 0, 0, 0);
    cyc(); cyc();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_instr", out_instr, 32'h0000_0013);
    chk("rst_imm", imm, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_ctrl", {26'd0, reg_write, alu_src, mem_read, mem_write, branch, jump}, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // addi x1,x0,5
    drive(1, 32'h0, 32'h0050_0093, 1, 0); cyc();
    chk("addi_valid", {31'd0, out_valid}, 32'd1);
    chk("addi_rd", {27'd0, rd}, 32'd1);
    chk("addi_rs1", {27'd0, rs1}, 32'd0);
    chk("addi_imm", imm, 32'd5);
    chk("addi_flags", {29'd0, alu_src, reg_write, illegal}, 32'b110);
    chk("addi_aluop", {28'd0, alu_op}, 32'd0);
    // beq-type branch with negative offset
    drive(1, 32'h8, 32'hFE20_8CE3, 1, 0); cyc();
    chk("br_branch", {31'd0, branch}, 32'd1);
    chk("br_rs", {22'd0, rs1, rs2}, {22'd0, 5'd1, 5'd2});
    chk("br_imm", imm, 32'hFFFF_FFF8);
    chk("br_regwr", {31'd0, reg_write}, 32'd0);
    // sw x1,8(x2)
    drive(1, 32'hC, 32'h0011_2423, 1, 0); cyc();
    chk("sw_imm", imm, 32'd8);
    chk("sw_flags", {28'd0, mem_write, mem_read, reg_write, alu_src}, 32'b1001);
    // lui x1,0x12345
    drive(1, 32'h10, 32'h1234_50B7, 1, 0); cyc();
    chk("lui_imm", imm, 32'h1234_5000);
    chk("lui_aluop", {28'd0, alu_op}, 32'd10);
    // sub x3,x1,x2
    drive(1, 32'h14, 32'h4020_81B3, 1, 0); cyc();
    chk("sub_aluop", {28'd0, alu_op}, 32'd1);
    chk("sub_fields", {15'd0, rd, rs1, rs2, alu_src, reg_write}, {15'd0, 5'd3, 5'd1, 5'd2, 1'b0, 1'b1});
    chk("sub_imm", imm, 32'd0);
    // addi x0,x0,1: write to x0 suppressed
    drive(1, 32'h18, 32'h0010_0013, 1, 0); cyc();
    chk("x0_regwr", {31'd0, reg_write}, 32'd0);
    // all-ones word is not a legal opcode
    drive(1, 32'h1C, 32'hFFFF_FFFF, 1, 0); cyc();
    chk("ill_illegal", {31'd0, illegal}, 32'd1);
    chk("ill_ctrl", {28'd0, reg_write, mem_write, branch, jump}, 32'd0);
    drive(0, 0, 0, 1, 0); cyc();
    chk("idle_instr", out_instr, 32'h0000_0013);

    // back-pressure: fill skid, hold, then drain in order
    drive(1, 32'h0, addi_w(32'h0), 0, 0); cyc();
    drive(1, 32'h4, addi_w(32'h4), 0, 0); cyc();
    chk("skid_in_ready", {31'd0, in_ready}, 32'd0);
    drive(1, 32'h8, addi_w(32'h8), 0, 0); cyc();
    chk("stall_pc", out_pc, 32'h0);
    chk("stall_instr", out_instr, addi_w(32'h0));
    drive(1, 32'h8, addi_w(32'h8), 1, 0); cyc();
    chk("drain_pc4", out_pc, 32'h4);
    cyc();
    chk("drain_pc8", out_pc, 32'h8);
    drive(0, 0, 0, 1, 0); cyc();
    chk("drain_empty", {31'd0, out_valid}, 32'd0);

    // flush from SKID with an incoming word
    drive(1, 32'h10, addi_w(32'h10), 0, 0); cyc();
    drive(1, 32'h14, addi_w(32'h14), 0, 0); cyc();
    drive(1, 32'h18, addi_w(32'h18), 0, 1); cyc();
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_in_ready", {31'd0, in_ready}, 32'd1);
    chk("fl_instr", out_instr, 32'h0000_0013);
    drive(0, 0, 0, 1, 0); cyc(); cyc();
    chk("fl_quiet", {31'd0, out_valid}, 32'd0);

    // reset while in SKID
    drive(1, 32'h20, addi_w(32'h20), 0, 0); cyc();
    drive(1, 32'h24, addi_w(32'h24), 0, 0); cyc();
    rst = 1'b1; cyc();
    chk("rs_valid", {31'd0, out_valid}, 32'd0);
    chk("rs_instr", out_instr, 32'h0000_0013);
    chk("rs_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    drive(0, 0, 0, 1, 0); cyc();

    // random traffic, scoreboard does the checking
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, i * 4, $urandom, $urandom_range(0, 2) != 0,
            $urandom_range(0, 19) == 0);
      cyc();
    end
    drive(0, 0, 0, 1, 0);
    cyc(); cyc(); cyc();
    chk("final_empty", {31'd0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
